// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that lets NREQ requesters share one W-bit JK storage bank.
// A granted command applies its captured J/K masks for a set number of consecutive cycles.
module jk_bank_sched #(
    parameter int unsigned W    = 4,
    parameter int unsigned NREQ = 2,
    parameter int unsigned CW   = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] J_IN,
    input  logic [NREQ*W-1:0] K_IN,
    input  logic [NREQ*CW-1:0] CNT_IN,
    output logic [NREQ-1:0]   GNT,
    output logic              BUSY,
    output logic              DONE,
    output logic [W-1:0]      Q,
    output logic [W-1:0]      Q_bar
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   rem, rem_n;
    logic [W-1:0]    j_r, j_n;
    logic [W-1:0]    k_r, k_n;
    logic [W-1:0]    q_n;
    logic [NREQ-1:0] gnt_n;
    logic            busy_n;
    logic            done_n;

    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic            win_vld;
    logic [CW-1:0]   cnt_sel;

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win     = '0;
        idx     = '0;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!win_vld && REQ[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign cnt_sel = CNT_IN[32'(win)*CW +: CW];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = rem;
        j_n     = j_r;
        k_n     = k_r;
        q_n     = Q;
        gnt_n   = '0;
        busy_n  = BUSY;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    j_n     = J_IN[32'(win)*W +: W];
                    k_n     = K_IN[32'(win)*W +: W];
                    rem_n   = (cnt_sel == '0) ? CW'(1) : cnt_sel;
                    gnt_n   = NREQ'(1) << win;
                    ptr_n   = (32'(win) + 32'd1 >= NREQ) ? '0 : PW'(32'(win) + 32'd1);
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                q_n = (j_r & ~Q) | (~k_r & Q);
                // rem is always >= 1 here; the <= guard keeps it from ever wrapping.
                if (rem <= CW'(1)) begin
                    rem_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    rem_n = rem - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            j_r   <= '0;
            k_r   <= '0;
            Q     <= '0;
            GNT   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            rem   <= rem_n;
            j_r   <= j_n;
            k_r   <= k_n;
            Q     <= q_n;
            GNT   <= gnt_n;
            BUSY  <= busy_n;
            DONE  <= done_n;
        end
    end

    assign Q_bar = ~Q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Scoreboard bench for jk_bank_sched: stimulus pushes hand-computed grants, per-application
// Q values and final Q at DONE; a negedge monitor pops and compares as the DUT presents them.
module tb_jk_bank_sched;

    localparam int unsigned W    = 4;
    localparam int unsigned NREQ = 2;
    localparam int unsigned CW   = 4;

    logic                CLK = 1'b0;
    logic                CLR = 1'b1;
    logic [NREQ-1:0]     REQ = '0;
    logic [NREQ*W-1:0]   J_IN = '0;
    logic [NREQ*W-1:0]   K_IN = '0;
    logic [NREQ*CW-1:0]  CNT_IN = '0;
    logic [NREQ-1:0]     GNT;
    logic                BUSY;
    logic                DONE;
    logic [W-1:0]        Q;
    logic [W-1:0]        Q_bar;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_g[$];
    logic [3:0] exp_q[$];
    logic [3:0] exp_d[$];

    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;

    jk_bank_sched #(.W(W), .NREQ(NREQ), .CW(CW)) dut (
        .CLK(CLK), .CLR(CLR), .REQ(REQ), .J_IN(J_IN), .K_IN(K_IN), .CNT_IN(CNT_IN),
        .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .Q(Q), .Q_bar(Q_bar)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge CLK) begin
        logic [3:0] e;
        logic [3:0] eb;
        logic [1:0] g;
        if (CLR) begin
            busy_prev = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (busy_prev) begin
                if (exp_q.size() == 0) fail_now("unexpected_application");
                else begin
                    e  = exp_q.pop_front();
                    eb = ~e;
                    check("q_apply", 32'(Q), 32'(e));
                    check("q_bar_apply", 32'(Q_bar), 32'(eb));
                end
            end
            if (GNT != '0) begin
                if (exp_g.size() == 0) fail_now("unexpected_grant");
                else begin
                    g = exp_g.pop_front();
                    check("gnt", 32'({GNT, BUSY}), 32'({g, 1'b1}));
                end
            end
            if (done_prev) check("done_one_cycle", 32'(DONE), 32'd0);
            if (DONE) begin
                if (exp_d.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_d.pop_front();
                    check("q_at_done", 32'({BUSY, Q}), 32'({1'b0, e}));
                end
            end
            busy_prev = BUSY;
            done_prev = DONE;
        end
    end

    task automatic set_op(input int i, input logic [3:0] j, input logic [3:0] k, input logic [3:0] c);
        J_IN[i*4 +: 4]   = j;
        K_IN[i*4 +: 4]   = k;
        CNT_IN[i*4 +: 4] = c;
    endtask

    task automatic wait_grant();
        logic got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge CLK);
            #1;
            if (GNT != '0) got = 1'b1;
        end
        if (!got) fail_now("grant_timeout");
    endtask

    // Called just after the grant edge; counts BUSY cycles up to DONE.
    task automatic wait_done(input int exp_busy);
        int  n;
        logic got;
        n   = BUSY ? 1 : 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge CLK);
            #1;
            if (DONE) got = 1'b1;
            else if (BUSY) n++;
        end
        if (!got) fail_now("done_timeout");
        else check("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic cmd(input int i, input logic [3:0] j, input logic [3:0] k,
                       input logic [3:0] c, input int exp_busy);
        set_op(i, j, k, c);
        REQ[i] = 1'b1;
        wait_grant();
        REQ[i] = 1'b0;
        wait_done(exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1 CLR = 1'b0;

        // Reset and idle
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle", 32'({Q, Q_bar, GNT, BUSY, DONE}), 32'({4'h0, 4'hF, 2'b00, 1'b0, 1'b0}));
        end
        @(posedge CLK);
        #1;

        // Single set
        exp_g.push_back(2'b01); exp_q.push_back(4'b1010); exp_d.push_back(4'b1010);
        cmd(0, 4'b1010, 4'b0000, 4'd1, 1);

        // Clear all bits back to zero
        exp_g.push_back(2'b01); exp_q.push_back(4'b0000); exp_d.push_back(4'b0000);
        cmd(0, 4'b0000, 4'b1111, 4'd1, 1);

        // Toggle burst of 3
        exp_g.push_back(2'b10);
        exp_q.push_back(4'b0011); exp_q.push_back(4'b0000); exp_q.push_back(4'b0011);
        exp_d.push_back(4'b0011);
        cmd(1, 4'b0011, 4'b0011, 4'd3, 3);

        // CNT=0 means a single toggle
        exp_g.push_back(2'b10); exp_q.push_back(4'b0000); exp_d.push_back(4'b0000);
        cmd(1, 4'b0011, 4'b0011, 4'd0, 1);

        // Set all, then clear/hold mix over two applications
        exp_g.push_back(2'b01); exp_q.push_back(4'b1111); exp_d.push_back(4'b1111);
        cmd(0, 4'b1111, 4'b0000, 4'd1, 1);
        exp_g.push_back(2'b10);
        exp_q.push_back(4'b0011); exp_q.push_back(4'b0011);
        exp_d.push_back(4'b0011);
        cmd(1, 4'b0000, 4'b1100, 4'd2, 2);

        // Fairness with REQ=11 held; operands scrambled during each RUN
        set_op(0, 4'b1000, 4'b0000, 4'd1);
        set_op(1, 4'b0001, 4'b1001, 4'd1);
        exp_g.push_back(2'b01); exp_g.push_back(2'b10); exp_g.push_back(2'b01); exp_g.push_back(2'b10);
        exp_q.push_back(4'b1011); exp_q.push_back(4'b0010); exp_q.push_back(4'b1010); exp_q.push_back(4'b0011);
        exp_d.push_back(4'b1011); exp_d.push_back(4'b0010); exp_d.push_back(4'b1010); exp_d.push_back(4'b0011);
        REQ = 2'b11;
        wait_grant();
        for (int i = 0; i < 4; i++) begin
            J_IN = 8'hFF; K_IN = 8'h00; CNT_IN = 8'hFF;
            wait_done(1);
            set_op(0, 4'b1000, 4'b0000, 4'd1);
            set_op(1, 4'b0001, 4'b1001, 4'd1);
            if (i == 3) REQ = 2'b00;
            else begin
                @(posedge CLK);
                #1;
                check("grant_after_done", 32'(GNT != '0), 32'd1);
            end
        end

        // Abort a CNT=5 toggle burst before its second application
        exp_g.push_back(2'b01); exp_q.push_back(4'b1100);
        set_op(0, 4'b1111, 4'b1111, 4'd5);
        REQ[0] = 1'b1;
        wait_grant();
        REQ[0] = 1'b0;
        @(posedge CLK);
        #7 CLR = 1'b1;
        #1;
        check("abort_now", 32'({Q, Q_bar, GNT, BUSY, DONE}), 32'({4'h0, 4'hF, 2'b00, 1'b0, 1'b0}));
        repeat (2) @(posedge CLK);
        #1 CLR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("no_done_after_abort", 32'({Q, BUSY, DONE}), 32'd0);
        end
        @(posedge CLK);
        #1;

        // First grant after abort favours requester 0
        set_op(0, 4'b0101, 4'b0000, 4'd1);
        set_op(1, 4'b1010, 4'b0000, 4'd1);
        exp_g.push_back(2'b01); exp_q.push_back(4'b0101); exp_d.push_back(4'b0101);
        REQ = 2'b11;
        wait_grant();
        REQ = 2'b00;
        wait_done(1);

        repeat (4) @(posedge CLK);
        #1;
        check("queues_drained", 32'(exp_g.size() + exp_q.size() + exp_d.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_bank_sched.md
Name: jk_bank_sched

Overview:
- Scheduler that shares one W-bit bank of JK-behaviour storage bits between NREQ requesters.
- Each requester submits per-bit J/K masks plus a repeat count.
- A round-robin arbiter grants one command at a time, and the block applies that JK update to the bank for the requested number of consecutive cycles.
- Sits between control logic (requesters) and any consumer of the Q/Q_bar state vector.

Parameters:
W, 4, width of the JK bank (number of bits).
NREQ, 2, number of requesters (at least 2).
CW, 4, width of each repeat-count field.

Ports:
CLK  input  1  clock; all state changes on rising edge.
CLR  input  1  asynchronous active-high reset.
REQ  input  NREQ  request; bit i is held by requester i until it sees GNT[i].
J_IN  input  NREQ*W  J masks; requester i occupies bits [i*W +: W].
K_IN  input  NREQ*W  K masks; same packing as J_IN.
CNT_IN  input  NREQ*CW  repeat counts; requester i occupies bits [i*CW +: CW].
GNT  output  NREQ  one-hot, one-cycle pulse: the winner's operands have been captured.
BUSY  output  1  high while a granted command is being applied.
DONE  output  1  one-cycle pulse after the final application of a command.
Q  output  W  bank state.
Q_bar  output  W  bitwise complement of Q.

Behaviour:
- Reset (CLR=1, asynchronous, any time):
  - Q=0 and Q_bar=all ones.
  - GNT=0, BUSY=0, DONE=0.
  - State=IDLE, rr pointer=0, remaining count=0.
  - Any in-flight command is aborted; no DONE is issued for it.
- Q_bar equals ~Q in every cycle, including during reset.
- States: IDLE and RUN.
- IDLE:
  - If REQ==0: stay in IDLE; GNT=0.
  - Otherwise the winner g is the first set REQ bit searched from index ptr upward, wrapping modulo NREQ.
  - At the edge:
    - Capture J_IN, K_IN and CNT_IN slices of g.
    - GNT<=onehot(g) for exactly one cycle.
    - ptr<=(g+1) mod NREQ.
    - rem<=(CNT==0 ? 1 : CNT).
    - BUSY<=1; state<=RUN.
  - Q is unchanged on the grant edge.
- RUN, at each edge:
  - Per bit: Q<=(J & ~Q) | (~K & Q).
    - J=0,K=0: hold. J=0,K=1: clear. J=1,K=0: set. J=1,K=1: toggle.
  - rem<=rem-1.
  - If rem==1 (last application): DONE<=1, BUSY<=0, state<=IDLE.
- Latency:
  - Grant edge is E.
  - Applications occur at edges E+1 … E+rem.
  - DONE is high in the cycle following edge E+rem.
  - Earliest next grant is edge E+rem+1, so at least one IDLE cycle separates commands.
- Captured operands are used for the whole command; REQ, J_IN, K_IN and CNT_IN changes during RUN are ignored.
- REQ bits are never granted during RUN; they are arbitrated when the block returns to IDLE.
- A requester that keeps REQ high after its GNT is treated as a new request. Because the rr pointer has moved past it, a competing requester wins first.
- CNT width rules:
  - CNT is unsigned and the maximum is 2^CW-1 applications.
  - CNT=0 is treated as 1 application.
  - rem never underflows.
- Simultaneous DONE and pending REQ: DONE is issued, and the grant follows at the next edge from IDLE.
- CLR asserted mid-RUN: immediate reset as above. After CLR deasserts, the first grant still favours index 0.

Test Plan:
- Reset and idle: CLR pulse, then REQ=0 for 5 cycles -> Q=0000, Q_bar=1111, GNT=0, BUSY=0 and DONE=0 throughout.
- Single set: req0 with J=1010, K=0000, CNT=1 -> GNT=01 at edge E; Q=1010 after E+1; DONE high for one cycle; BUSY high exactly 1 cycle.
- Toggle burst: Q=0000, req1 with J=K=0011, CNT=3 -> Q sequence 0011, 0000, 0011 on edges E+1..E+3; DONE once; CNT=0 variant yields exactly one toggle.
- Fairness:
  - REQ=11 held continuously with distinct masks -> grants alternate 01, 10, 01, 10, and each grant follows the previous DONE by one edge.
  - Operand changes on either requester during RUN do not affect Q.
- Clear/hold mix: Q=1111, J=0000, K=1100, CNT=2 -> Q=0011 after first application and remains 0011 after the second.
- Abort: CLR asserted at the second edge of a CNT=5 toggle burst -> Q=0000 immediately; no DONE; next REQ=11 is granted to requester 0.
